fb_pattern_writer: RTL and testbench

- Frame-buffer producer that sits directly upstream of the SDRAM controller's write port in the SDRAM-to-VGA path.
- Fills the back buffer of a two-unit ping-pong frame store with a column-index test pattern, using burst write requests.
- Swaps front/back buffers on the VGA frame_sync pulse and publishes the display base address to the VGA read side.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_pattern_gen.sv | 49 ++++
 rtl/fb_pattern_writer.sv | 157 +++++++++++++++
 tb/tb_fb_pattern_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, FSM state encoding and burst sizing for the frame-buffer pattern writer.
package fb_pkg;

  localparam int unsigned FB_UNIT_WORDS = 1048576;
  localparam int unsigned FB_ADDR_W     = 21;
  localparam int unsigned FB_DATA_W     = 16;
  localparam int unsigned FB_BURST_LEN  = 256;
  localparam int unsigned FB_LEN_W      = 9;

  typedef logic [2:0] fb_state_t;

  localparam fb_state_t StIdle     = 3'd0;
  localparam fb_state_t StReq      = 3'd1;
  localparam fb_state_t StData     = 3'd2;
  localparam fb_state_t StWaitDone = 3'd3;
  localparam fb_state_t StFilled   = 3'd4;

  function automatic logic [FB_LEN_W-1:0] fb_burst_len(input int unsigned remaining,
                                                       input int unsigned max_len);
    int unsigned len;
    len = (remaining < max_len) ? remaining : max_len;
    return FB_LEN_W'(len);
  endfunction

endpackage

// File: rtl/fb_pattern_gen.sv
// Word index and column counter pair producing the column-index test pattern.
module fb_pattern_gen #(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DATA_DEPTH = 30720,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IDX_W      = $clog2(DATA_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              adv_i,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ColW-1:0]  col_q, col_d;

  always_comb begin
    idx_d = idx_q;
    col_d = col_q;
    if (clear_i) begin
      idx_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
      col_d = (col_q == ColW'(WIDTH - 1)) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      col_q <= '0;
    end else begin
      idx_q <= idx_d;
      col_q <= col_d;
    end
  end

  assign word_idx_o = idx_q;
  assign data_o     = DATA_W'(col_q);
  // High once every word of the frame has been handed to the controller.
  assign last_o     = (idx_q == IDX_W'(DATA_DEPTH));

endmodule

// File: rtl/fb_pattern_writer.sv
// Fills the back half of a ping-pong frame store with a column pattern via burst writes and
// swaps buffers on VGA frame sync.
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DATA_DEPTH = 30720,
  parameter int unsigned UNIT_WORDS = FB_UNIT_WORDS,
  parameter int unsigned BURST_LEN  = FB_BURST_LEN,
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = FB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_done,
  input  logic                frame_sync,
  output logic                mem_wr_req,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [FB_LEN_W-1:0] mem_wr_len,
  input  logic                mem_wr_ack,
  input  logic                mem_wr_data_req,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic                mem_wr_done,
  output logic [ADDR_W-1:0]   disp_base_addr,
  output logic                fb_valid,
  output logic                overrun
);

  localparam int unsigned IdxW = $clog2(DATA_DEPTH + 1);

  fb_state_t           state_q, state_d;
  logic                wr_sel_q, wr_sel_d;
  logic                fill_done_q, fill_done_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FB_LEN_W-1:0] len_q, len_d;
  logic [FB_LEN_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   disp_q, disp_d;
  logic                fb_valid_q, fb_valid_d;
  logic                overrun_q, overrun_d;

  logic            pg_clear, pg_adv, pg_last;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     unit_base;

  assign unit_base = wr_sel_q ? 32'(UNIT_WORDS) : 32'd0;
  // Requests past the granted length are ignored.
  assign pg_adv = (state_q == StData) && mem_wr_data_req && (cnt_q < len_q);

  fb_pattern_gen #(
    .WIDTH      (WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .DATA_W     (DATA_W),
    .IDX_W      (IdxW)
  ) u_pattern_gen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (pg_clear),
    .adv_i      (pg_adv),
    .word_idx_o (word_idx),
    .data_o     (mem_wr_data),
    .last_o     (pg_last)
  );

  always_comb begin
    state_d     = state_q;
    wr_sel_d    = wr_sel_q;
    fill_done_d = fill_done_q;
    req_d       = req_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    fb_valid_d  = fb_valid_q;
    pg_clear    = 1'b0;
    overrun_d   = frame_sync && (state_q != StFilled);

    case (state_q)
      StIdle: begin
        if (init_done && !fill_done_q) begin
          addr_d  = ADDR_W'(unit_base + 32'(word_idx));
          len_d   = fb_burst_len(DATA_DEPTH - 32'(word_idx), BURST_LEN);
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_wr_ack) begin
          req_d   = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        if (pg_adv) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (mem_wr_done) begin
          if (pg_last) begin
            fill_done_d = 1'b1;
            state_d     = StFilled;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFilled: begin
        if (frame_sync) begin
          disp_d      = ADDR_W'(unit_base);
          wr_sel_d    = ~wr_sel_q;
          fb_valid_d  = 1'b1;
          fill_done_d = 1'b0;
          pg_clear    = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_sel_q    <= 1'b0;
      fill_done_q <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= ADDR_W'(UNIT_WORDS);
      fb_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      fill_done_q <= fill_done_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      fb_valid_q  <= fb_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_wr_req     = req_q;
  assign mem_wr_addr    = addr_q;
  assign mem_wr_len     = len_q;
  assign disp_base_addr = disp_q;
  assign fb_valid       = fb_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Randomised bench for fb_pattern_writer: a behavioural SDRAM write-port model fills a sparse
// memory, which is then compared against the column pattern computed arithmetically.
module tb_fb_pattern_writer;

  localparam int unsigned WIDTH   = 400;
  localparam int unsigned DEPTH   = 1000;
  localparam int unsigned UNIT    = 1048576;
  localparam int unsigned BL      = 256;
  localparam int unsigned AW      = 21;
  localparam int unsigned DW      = 16;
  localparam int          TIMEOUT = 20000;
  localparam int          NBURST  = (DEPTH + BL - 1) / BL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          fs_main = 1'b0;
  logic          fs_ctl = 1'b0;
  logic          frame_sync;
  logic          ack = 1'b0;
  logic          dreq = 1'b0;
  logic          done = 1'b0;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [8:0]    mem_wr_len;
  logic [DW-1:0] mem_wr_data;
  logic [AW-1:0] disp_base_addr;
  logic          fb_valid;
  logic          overrun;

  assign frame_sync = fs_main | fs_ctl;
  always #5 clk = ~clk;

  fb_pattern_writer #(
    .WIDTH      (WIDTH),
    .DATA_DEPTH (DEPTH),
    .UNIT_WORDS (UNIT),
    .BURST_LEN  (BL),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .init_done       (init_done),
    .frame_sync      (frame_sync),
    .mem_wr_req      (mem_wr_req),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_len      (mem_wr_len),
    .mem_wr_ack      (ack),
    .mem_wr_data_req (dreq),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_done     (done),
    .disp_base_addr  (disp_base_addr),
    .fb_valid        (fb_valid),
    .overrun         (overrun)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model state
  logic [DW-1:0] mem [int];
  int q_addr[$];
  int q_len[$];
  int done_cnt = 0;
  int hold_err = 0;
  int ack_delay = 0;
  int mode = 0;       // 0 continuous, 1 one-on/three-off, 2 random
  bit sync_on_last = 1'b0;
  bit in_data = 1'b0;
  int ov_cnt = 0;

  always @(negedge clk) if (overrun) ov_cnt++;

  initial begin : ctl
    int a, l, n, ph, dly;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem_wr_req) begin
        a = int'(mem_wr_addr);
        l = int'(mem_wr_len);
        q_addr.push_back(a);
        q_len.push_back(l);
        dly = (mode == 2) ? int'($urandom_range(0, 12)) : ack_delay;
        for (int k = 0; k < dly; k++) begin
          @(posedge clk); #1;
          if (!mem_wr_req || int'(mem_wr_addr) != a || int'(mem_wr_len) != l) hold_err++;
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        n = 0;
        ph = 0;
        in_data = 1'b1;
        while (n < l) begin
          case (mode)
            0:       dreq = 1'b1;
            1:       dreq = (ph % 4 == 0);
            default: dreq = 1'($urandom_range(0, 1));
          endcase
          ph++;
          if (dreq) begin
            mem[a + n] = mem_wr_data;
            n++;
          end
          @(posedge clk); #1;
        end
        in_data = 1'b0;
        // One surplus data request that the writer must ignore
        dreq = 1'b1;
        @(posedge clk); #1;
        dreq = 1'b0;
        done = 1'b1;
        fs_ctl = sync_on_last && ((a % UNIT) + l == DEPTH);
        @(posedge clk); #1;
        done = 1'b0;
        fs_ctl = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic wait_dones(input int target, input string tag);
    int c = 0;
    while (done_cnt < target && c < TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq(tag, done_cnt, target);
  endtask

  task automatic pulse_sync();
    fs_main = 1'b1;
    @(posedge clk); #1;
    fs_main = 1'b0;
  endtask

  task automatic check_fill(input string tag, input int base);
    int errs = 0;
    int exp_len;
    check_eq({tag, "_nbursts"}, q_addr.size(), NBURST);
    for (int k = 0; k < NBURST; k++) begin
      exp_len = (int'(DEPTH) - k * int'(BL) < int'(BL)) ? int'(DEPTH) - k * int'(BL) : int'(BL);
      if (q_addr.size() > 0) begin
        check_eq({tag, "_addr"}, q_addr.pop_front(), base + k * int'(BL));
        check_eq({tag, "_len"}, q_len.pop_front(), exp_len);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++)
      if (!mem.exists(base + i) || mem[base + i] != DW'(i % int'(WIDTH))) errs++;
    check_eq({tag, "_mem_errs"}, errs, 0);
    check_eq({tag, "_mem_words"}, mem.num(), DEPTH);
    mem.delete();
    q_addr.delete();
    q_len.delete();
  endtask

  initial begin : main
    int c;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", mem_wr_req, 0);
    check_eq("rst_addr", mem_wr_addr, 0);
    check_eq("rst_len", mem_wr_len, 0);
    check_eq("rst_disp", disp_base_addr, UNIT);
    check_eq("rst_fb_valid", fb_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    init_done = 1'b1;

    // Fill 0: continuous data, immediate ack
    wait_dones(NBURST, "fill0_done");
    repeat (5) @(posedge clk);
    #1;
    check_eq("fill0_req_idle", mem_wr_req, 0);
    check_eq("fill0_fb_valid", fb_valid, 0);
    check_eq("fill0_disp", disp_base_addr, UNIT);
    check_fill("fill0", 0);

    // Swap 1, then fill 1 with gapped data, slow ack, mid-fill sync and init_done drop
    mode = 1;
    ack_delay = 10;
    pulse_sync();
    check_eq("swap1_disp", disp_base_addr, 0);
    check_eq("swap1_fb_valid", fb_valid, 1);
    wait_dones(NBURST + 1, "fill1_b1");
    pulse_sync();
    init_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_overrun_once", ov_cnt, 1);
    check_eq("mid_no_swap", disp_base_addr, 0);
    wait_dones(NBURST + 2, "fill1_b2");
    repeat (50) @(posedge clk);
    #1;
    check_eq("init_hold_bursts", q_addr.size(), 2);
    check_eq("init_hold_req", mem_wr_req, 0);
    init_done = 1'b1;
    wait_dones(2 * NBURST, "fill1_done");
    repeat (5) @(posedge clk);
    #1;
    check_eq("fill1_req_hold", hold_err, 0);
    check_eq("fill1_disp", disp_base_addr, 0);
    check_fill("fill1", UNIT);

    // Swap 2, fill 2 with a sync coinciding with the final done
    mode = 0;
    ack_delay = 0;
    sync_on_last = 1'b1;
    pulse_sync();
    check_eq("swap2_disp", disp_base_addr, UNIT);
    wait_dones(3 * NBURST, "fill2_done");
    sync_on_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("coinc_overrun", ov_cnt, 2);
    check_eq("coinc_no_swap", disp_base_addr, UNIT);
    check_eq("coinc_req_idle", mem_wr_req, 0);
    check_fill("fill2", 0);

    // Swap 3, fully random controller timing
    mode = 2;
    pulse_sync();
    check_eq("swap3_disp", disp_base_addr, 0);
    wait_dones(4 * NBURST, "fill3_done");
    repeat (5) @(posedge clk);
    #1;
    check_eq("fill3_overrun", ov_cnt, 2);
    check_fill("fill3", UNIT);

    // Swap 4, then asynchronous reset in the middle of a data phase
    pulse_sync();
    check_eq("swap4_disp", disp_base_addr, UNIT);
    wait_dones(4 * NBURST + 1, "fill4_b1");
    c = 0;
    while (!in_data && c < TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("rst_wait_data", in_data, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req", mem_wr_req, 0);
    check_eq("arst_addr", mem_wr_addr, 0);
    check_eq("arst_len", mem_wr_len, 0);
    check_eq("arst_disp", disp_base_addr, UNIT);
    check_eq("arst_fb_valid", fb_valid, 0);
    check_eq("arst_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
